// File: rtl/td4_run_ctrl.sv
// Run controller for a TD4-style 4-bit CPU. It holds the 16x8 program ROM,
// loads it byte by byte, and gates the CPU clock enable for run / single-step.
// Optional breakpoint support is built when TD4_RUN_CTRL_BREAKPOINT_EN is defined.
module td4_run_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    input  logic [3:0] pc_in,
    output logic [7:0] instr,
    output logic       cpu_ce,
    output logic       cpu_rst,
    output logic [1:0] state,
    output logic [7:0] cycle_cnt
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
    ,
    input  logic       bp_en,
    input  logic [3:0] bp_addr
`endif
);

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2,
        StLoad = 2'd3
    } state_e;

    localparam logic [1:0] CmdHalt = 2'd0;
    localparam logic [1:0] CmdRun  = 2'd1;
    localparam logic [1:0] CmdStep = 2'd2;
    localparam logic [1:0] CmdLoad = 2'd3;

    state_e      state_q, state_d;
    logic [3:0]  wptr_q, wptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  mem_q [16];
    logic        cpu_rst_q;
    logic        bp_hit;
    logic        wr_en;

`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
    // Set during the first RUN cycle after leaving HALT so a run can resume
    // from the address it stopped on.
    logic        first_q, first_d;

    // Breakpoint match, suppressed on the first RUN cycle.
    always_comb begin
        bp_hit  = (state_q == StRun) && bp_en && (pc_in == bp_addr) && !first_q;
        first_d = (state_q == StHalt) && cmd_valid && (cmd == CmdRun);
    end

    // Resume-from-breakpoint flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b0;
        end else begin
            first_q <= first_d;
        end
    end
`else
    // Without breakpoints RUN only stops on a HALT command.
    always_comb begin
        bp_hit = 1'b0;
    end
`endif

    // Outputs decoded from the current state.
    always_comb begin
        cpu_ce    = ((state_q == StRun) && !bp_hit) || (state_q == StStep);
        ld_ready  = (state_q == StLoad);
        wr_en     = ld_ready && ld_valid;
        instr     = mem_q[pc_in];
        state     = state_q;
        cycle_cnt = cnt_q;
        cpu_rst   = cpu_rst_q;
    end

    // Next-state, write pointer and cycle counter.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q + {7'd0, cpu_ce};
        unique case (state_q)
            StHalt: begin
                if (cmd_valid) begin
                    case (cmd)
                        CmdRun:  state_d = StRun;
                        CmdStep: state_d = StStep;
                        CmdLoad: begin
                            state_d = StLoad;
                            wptr_d  = 4'd0;
                            cnt_d   = 8'd0;
                        end
                        default: state_d = StHalt;
                    endcase
                end
            end
            StRun: begin
                if ((cmd_valid && (cmd == CmdHalt)) || bp_hit) begin
                    state_d = StHalt;
                end
            end
            StStep: begin
                state_d = StHalt;
            end
            StLoad: begin
                if (wr_en) begin
                    // Last location ends the load; the pointer never wraps.
                    if (wptr_q == 4'hF) begin
                        state_d = StHalt;
                    end else begin
                        wptr_d = wptr_q + 4'd1;
                    end
                end
                if (cmd_valid && (cmd == CmdHalt)) begin
                    state_d = StHalt;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // State, pointer, counter and CPU reset request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StHalt;
            wptr_q    <= 4'd0;
            cnt_q     <= 8'd0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            cpu_rst_q <= (state_d == StLoad);
        end
    end

    // Program memory; cleared by reset so a reset never leaves a partial write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_q[wptr_q] <= ld_data;
        end
    end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Self-checking bench for td4_run_ctrl: directed scenarios, then random traffic,
// all compared every cycle against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_td4_run_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [3:0] pc_in;
    logic [7:0] instr;
    logic       cpu_ce;
    logic       cpu_rst;
    logic [1:0] state;
    logic [7:0] cycle_cnt;
    logic       bp_en;
    logic [3:0] bp_addr;

`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
    localparam bit BpOn = 1'b1;
`else
    localparam bit BpOn = 1'b0;
`endif

    td4_run_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .pc_in     (pc_in),
        .instr     (instr),
        .cpu_ce    (cpu_ce),
        .cpu_rst   (cpu_rst),
        .state     (state),
        .cycle_cnt (cycle_cnt)
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
        ,
        .bp_en     (bp_en),
        .bp_addr   (bp_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;
    bit pc_follow = 1'b0;

    // Behavioural model: mode 0=HALT 1=RUN 2=STEP 3=LOAD.
    int         m_mode;
    logic [7:0] m_mem [16];
    int         m_wptr;
    logic [7:0] m_cnt;
    logic       m_cpu_rst;
    int         m_run_age;
    logic       m_prev_ce;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        n_total++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic bp_hit_m();
        return BpOn && bp_en && (pc_in == bp_addr) && (m_run_age != 0);
    endfunction

    function automatic logic exp_ce();
        return ((m_mode == 1) && !bp_hit_m()) || (m_mode == 2);
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_wptr    = 0;
        m_cnt     = 8'd0;
        m_cpu_rst = 1'b1;
        m_run_age = 0;
        m_prev_ce = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    endtask

    task automatic model_step();
        logic ce;
        logic hit;
        ce  = exp_ce();
        hit = (m_mode == 1) && bp_hit_m();
        m_prev_ce = ce;
        if (ce) m_cnt = m_cnt + 8'd1;
        case (m_mode)
            0: begin
                if (cmd_valid) begin
                    if (cmd == 2'd1) begin
                        m_mode = 1;
                        m_run_age = 0;
                    end else if (cmd == 2'd2) begin
                        m_mode = 2;
                    end else if (cmd == 2'd3) begin
                        m_mode = 3;
                        m_wptr = 0;
                        m_cnt  = 8'd0;
                    end
                end
            end
            1: begin
                if ((cmd_valid && cmd == 2'd0) || hit) m_mode = 0;
                else m_run_age++;
            end
            2: m_mode = 0;
            default: begin
                if (ld_valid) begin
                    m_mem[m_wptr] = ld_data;
                    if (m_wptr == 15) m_mode = 0;
                    else m_wptr++;
                end
                if (cmd_valid && cmd == 2'd0) m_mode = 0;
            end
        endcase
        m_cpu_rst = (m_mode == 3);
    endtask

    // Model advances on every clock edge outside reset.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && chk_on) model_step();
        end
    end

    // Compare process: all outputs checked against the model each cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("state", {6'd0, state}, 8'(m_mode));
            chk("cpu_ce", {7'd0, cpu_ce}, {7'd0, exp_ce()});
            chk("cpu_rst", {7'd0, cpu_rst}, {7'd0, m_cpu_rst});
            chk("ld_ready", {7'd0, ld_ready}, {7'd0, (m_mode == 3) ? 1'b1 : 1'b0});
            chk("cycle_cnt", cycle_cnt, m_cnt);
            chk("instr", instr, m_mem[pc_in]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (pc_follow) pc_in = pc_in + {3'd0, m_prev_ce};
    endtask

    task automatic issue(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; ld_valid = 1'b0; ld_data = 8'h00;
        pc_in = 4'd0; bp_en = 1'b0; bp_addr = 4'd0;
        model_reset();
        chk_on = 1'b1;
        #2;
        // Reset values pinned literally.
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_ce", {7'd0, cpu_ce}, 8'd0);
        chk("rst_cpu_rst", {7'd0, cpu_rst}, 8'd1);
        chk("rst_ld_ready", {7'd0, ld_ready}, 8'd0);
        chk("rst_cnt", cycle_cnt, 8'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("cpu_rst_released", {7'd0, cpu_rst}, 8'd0);

        // Scenario 1: full 16-byte load.
        issue(2'd3);
        ld_valid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            ld_data = 8'(n);
            cyc();
        end
        ld_valid = 1'b0;
        chk("s1_state", {6'd0, state}, 8'd0);
        for (int n = 0; n < 16; n++) begin
            pc_in = 4'(n);
            #1;
            chk("s1_instr", instr, 8'(n));
            cyc();
        end

        // Scenario 2: aborted load keeps written bytes.
        do_reset();
        issue(2'd3);
        ld_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            ld_data = 8'hA1 + 8'(n);
            cyc();
        end
        ld_valid = 1'b0;
        issue(2'd0);
        #1;
        chk("s2_state", {6'd0, state}, 8'd0);
        for (int n = 0; n < 16; n++) begin
            pc_in = 4'(n);
            #1;
            chk("s2_instr", instr, (n < 5) ? 8'hA1 + 8'(n) : 8'h00);
            cyc();
        end

        // Scenario 3: ten RUN cycles.
        issue(2'd1);
        for (int n = 0; n < 9; n++) cyc();
        issue(2'd0);
        #1;
        chk("s3_cnt", cycle_cnt, 8'd10);
        chk("s3_state", {6'd0, state}, 8'd0);

        // Scenario 4: three steps, the last followed directly by RUN.
        do_reset();
        issue(2'd2);
        cyc(); cyc();
        issue(2'd2);
        cyc();
        issue(2'd2);
        issue(2'd1);
        cyc(); cyc();
        #1;
        chk("s4_cnt", cycle_cnt, 8'd3);
        chk("s4_state", {6'd0, state}, 8'd0);

`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
        // Scenario 5: breakpoint at 4, then resume from it.
        do_reset();
        pc_in = 4'd0; bp_en = 1'b1; bp_addr = 4'd4;
        pc_follow = 1'b1;
        issue(2'd1);
        for (int n = 0; n < 6; n++) cyc();
        #1;
        chk("s5_bp_state", {6'd0, state}, 8'd0);
        chk("s5_bp_cnt", cycle_cnt, 8'd4);
        chk("s5_bp_pc", {4'd0, pc_in}, 8'd4);
        issue(2'd1);
        for (int n = 0; n < 5; n++) cyc();
        #1;
        chk("s5_resume_state", {6'd0, state}, 8'd1);
        chk("s5_resume_cnt", cycle_cnt, 8'd9);
        issue(2'd0);
        pc_follow = 1'b0;
        bp_en = 1'b0;
`endif

        // Scenario 6: reset in the middle of a run.
        do_reset();
        issue(2'd3);
        ld_valid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            ld_data = 8'($urandom_range(1, 255));
            cyc();
        end
        ld_valid = 1'b0;
        issue(2'd1);
        for (int n = 0; n < 55; n++) cyc();
        #1;
        chk("s6_cnt_before", cycle_cnt, 8'h37);
        rst = 1'b1;
        model_reset();
        #1;
        chk("s6_ce", {7'd0, cpu_ce}, 8'd0);
        chk("s6_cnt", cycle_cnt, 8'd0);
        chk("s6_state", {6'd0, state}, 8'd0);
        for (int n = 0; n < 16; n++) begin
            pc_in = 4'(n);
            #1;
            chk("s6_mem", instr, 8'h00);
            cyc();
        end
        rst = 1'b0;
        cyc();

        // Random traffic checked by the compare process.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                cmd_valid = ($urandom_range(0, 7) == 0);
                cmd       = 2'($urandom_range(0, 3));
                ld_valid  = $urandom_range(0, 1) == 1;
                ld_data   = 8'($urandom);
                pc_in     = 4'($urandom);
                bp_en     = $urandom_range(0, 1) == 1;
                bp_addr   = 4'($urandom);
                cyc();
            end
        end
        cmd_valid = 1'b0;
        ld_valid  = 1'b0;
        cyc();
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/td4_run_ctrl.md
TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 SHALL have these ports, all single-clock in the clk domain:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command strobe.
- cmd  in  2  command code: 0=HALT, 1=RUN, 2=STEP, 3=LOAD.
- ld_valid  in  1  load byte strobe.
- ld_data  in  8  program byte.
- ld_ready  out  1  load byte accepted this cycle.
- pc_in  in  4  CPU program counter (CPU address output).
- instr  out  8  instruction byte to the CPU data input.
- cpu_ce  out  1  CPU clock enable.
- cpu_rst  out  1  CPU reset request, active-high.
- state  out  2  current state: 0=HALT, 1=RUN, 2=STEP, 3=LOAD.
- cycle_cnt  out  8  count of cpu_ce cycles.
- bp_en  in  1  breakpoint enable (BREAKPOINT_EN only).
- bp_addr  in  4  breakpoint address (BREAKPOINT_EN only).

Function
REQ-002 SHALL hold a 16x8 program memory; instr = mem[pc_in], combinational.
REQ-003 SHALL implement the state machine HALT, RUN, STEP, LOAD with registered transitions on clk.
REQ-004 Command handling (cmd_valid=1 sampled at the clk edge):
- HALT state: RUN->RUN, STEP->STEP, LOAD->LOAD; HALT is a no-op.
- RUN state: HALT->HALT; all other commands are ignored.
- STEP state: all commands are ignored.
- LOAD state: HALT aborts the load to HALT; all other commands are ignored.
REQ-005 STEP SHALL last exactly one cycle, then return to HALT unconditionally.
REQ-006 cpu_ce SHALL be 1 in every RUN cycle (subject to REQ-014) and in the STEP cycle, and 0 otherwise.
REQ-007 cpu_rst SHALL be 1 while state=LOAD and 0 otherwise.
REQ-008 On entry to LOAD, the write pointer wptr and cycle_cnt SHALL clear to 0.
REQ-009 ld_ready SHALL equal 1 while state=LOAD.
REQ-010 Each cycle with ld_valid&ld_ready SHALL write ld_data to mem[wptr] and increment wptr.
REQ-011 The write to mem[15] SHALL return the state to HALT on the next cycle; wptr does not wrap.
REQ-012 On a LOAD abort, already-written bytes SHALL be kept and unwritten locations SHALL be unchanged.
REQ-013 cycle_cnt SHALL increment by 1 in each cycle with cpu_ce=1, wrapping 0xFF->0x00.

Reset
REQ-015 While rst=1, asynchronously:
- state=HALT, cpu_ce=0, cpu_rst=1, ld_ready=0.
- cycle_cnt=0, wptr=0, all memory bytes=0x00.
REQ-016 After rst deasserts, cpu_rst SHALL be 0 from the first clk edge, with state=HALT.
REQ-017 Reset in mid-LOAD or mid-RUN SHALL abandon the operation with no partial write on the reset edge.

Configuration
REQ-014 Macro TD4_RUN_CTRL_BREAKPOINT_EN:
- Defined: bp_en and bp_addr exist.
- In RUN with bp_en=1 and pc_in==bp_addr, cpu_ce SHALL be 0 in that cycle and the state SHALL be HALT next cycle.
- The breakpoint check SHALL be ignored in the first RUN cycle after entry from HALT, so a run can resume from a breakpoint.
- STEP SHALL ignore the breakpoint.
- Undefined: the ports are absent and RUN continues until a HALT command.
REQ-018 All other behaviour SHALL be identical with and without the macro.

Verification
REQ-019 Scenario 1: reset; LOAD; 16 bytes 0x00..0x0F on consecutive cycles.
-> ld_ready=1 for 16 cycles, cpu_rst=1 throughout, state=HALT after byte 16, and instr=0x0N for pc_in=N.
REQ-020 Scenario 2: LOAD; 5 bytes 0xA1..0xA5; HALT command.
-> mem[0..4]=0xA1..0xA5, mem[5..15]=0x00, state=HALT.
REQ-021 Scenario 3: from HALT, RUN; HALT command 10 cycles later.
-> cpu_ce=1 for exactly 10 cycles, cycle_cnt=10, state=HALT.
REQ-022 Scenario 4: STEP issued 3 times, with STEP+RUN back-to-back.
-> 1 cpu_ce pulse per STEP, cycle_cnt=3, and the RUN issued during STEP is ignored.
REQ-023 Scenario 5 (BREAKPOINT_EN defined): bp_en=1, bp_addr=4, pc_in counting 0,1,2,... per cpu_ce; RUN.
-> cpu_ce low when pc_in=4, state=HALT; a second RUN executes pc 4 and continues.
REQ-024 Scenario 6: rst pulsed mid-RUN with cycle_cnt=0x37.
-> immediately cpu_ce=0, cycle_cnt=0, memory=0x00, state=HALT.
